// File: rtl/dsa_out_word_packer_if.sv
// Host-side bus of the output word packer: OUT_ADDR pointer load, OUT_DATA
// pop and the status readbacks. The packer owns the slave modport, the
// host bus bridge drives the master modport.
interface dsa_out_word_packer_if #(
  parameter int PIX_ADDR_W = 10,
  parameter int LEVEL_W    = 3
);
  // Handshake: pop is a single-cycle request with no ready. The head word is
  // valid on rdata whenever level != 0, in the same cycle the pop is raised,
  // and is consumed at the clock edge that samples pop. A pop with level == 0
  // reads 0 and still advances word_ptr. ptr_load is a single-cycle strobe
  // that restarts the stream and takes priority over everything else.
  logic                  ptr_load;
  logic [15:0]           ptr_wdata;
  logic [PIX_ADDR_W:0]   pix_count;
  logic                  pop;
  logic [31:0]           rdata;
  logic [15:0]           word_ptr;
  logic [LEVEL_W-1:0]    level;
  logic                  underflow;
  logic [15:0]           underflow_cnt;

  modport master (
    output ptr_load, ptr_wdata, pix_count, pop,
    input  rdata, word_ptr, level, underflow, underflow_cnt
  );

  modport slave (
    input  ptr_load, ptr_wdata, pix_count, pop,
    output rdata, word_ptr, level, underflow, underflow_cnt
  );
endinterface

// File: rtl/dsa_out_word_packer.sv
// Output word packer: prefetches four 8-bit output pixels from the output
// BRAM read port, packs them little-endian into a 32-bit word and queues the
// words in a small FIFO so each host OUT_DATA read is served in the same
// cycle. Optional macro DSA_PACK_UNDERFLOW_CNT_EN enables the saturating
// underflow event counter; without it underflow_cnt reads 0.
module dsa_out_word_packer #(
  parameter int IMG_MAX_W  = 32,
  parameter int IMG_MAX_H  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int PIX_ADDR_W = $clog2(IMG_MAX_W * IMG_MAX_H)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dsa_out_word_packer_if.slave   bus,
  output logic [PIX_ADDR_W-1:0]  mem_addr,
  input  logic [7:0]             mem_q,
  output logic [1:0]             state_dbg
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0]            state;
  logic [1:0]            idx;
  logic [15:0]           fetch_ptr;
  logic [15:0]           word_ptr;
  logic [16:0]           end_words;
  logic [PIX_ADDR_W:0]   pix_cnt_q;
  logic [31:0]           word_sr;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LEVEL_W-1:0]    level;
  logic [16:0]           skip_cnt;
  logic                  underflow;

  logic                  start_idle;
  logic                  start_cap;
  logic                  pop_hit;
  logic                  pop_empty;
  logic                  pending;
  logic                  uf_pop;
  logic                  push_req;
  logic                  discard;
  logic                  push;
  logic                  cap_en;
  logic [1:0]            cap_sel;
  logic [7:0]            cap_byte;
  logic [31:0]           push_word;

  assign state_dbg     = state;
  assign bus.word_ptr  = word_ptr;
  assign bus.level     = level;
  assign bus.underflow = underflow;

  // Fetch scheduling, pop classification and byte capture/masking.
  always_comb begin
    // A fetch may start only while words remain and a FIFO slot can be reserved.
    start_idle = ({1'b0, fetch_ptr} < end_words) && (level < LEVEL_W'(FIFO_DEPTH));
    // From CAPTURE the word being pushed still holds its slot this cycle.
    start_cap  = (({1'b0, fetch_ptr} + 17'd1) < end_words) &&
                 (level < LEVEL_W'(FIFO_DEPTH - 1));
    pop_hit    = bus.pop && (level != '0);
    pop_empty  = bus.pop && (level == '0);
    // With the FIFO empty the requested word index is fetch_ptr + skip_cnt.
    pending    = ({2'b00, fetch_ptr} + {1'b0, skip_cnt}) < {1'b0, end_words};
    uf_pop     = pop_empty && pending;
    push_req   = (state == S_CAPTURE);
    // Words already claimed by underflow pops are dropped to keep alignment.
    discard    = push_req && ((skip_cnt != '0) || uf_pop);
    push       = push_req && !discard;
    cap_en     = ((state == S_ISSUE) && (idx != 2'd0)) || (state == S_CAPTURE);
    cap_sel    = (state == S_CAPTURE) ? 2'd3 : (idx - 2'd1);
    cap_byte   = (32'({fetch_ptr, cap_sel}) < 32'(pix_cnt_q)) ? mem_q : 8'h00;
    push_word  = {cap_byte, word_sr[31:8]};
    mem_addr   = (state == S_ISSUE) ? PIX_ADDR_W'({fetch_ptr, idx}) : '0;
    bus.rdata  = (level != '0) ? fifo_mem[rd_ptr] : 32'd0;
  end

  // Fetch FSM, pointers, FIFO bookkeeping and the sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      fetch_ptr <= 16'd0;
      word_ptr  <= 16'd0;
      end_words <= 17'd0;
      pix_cnt_q <= '0;
      word_sr   <= 32'd0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      skip_cnt  <= 17'd0;
      underflow <= 1'b0;
    end else if (bus.ptr_load) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      fetch_ptr <= bus.ptr_wdata;
      word_ptr  <= bus.ptr_wdata;
      end_words <= 17'((32'(bus.pix_count) + 32'd3) >> 2);
      pix_cnt_q <= bus.pix_count;
      word_sr   <= 32'd0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      skip_cnt  <= 17'd0;
      underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_idle) begin
            state <= S_ISSUE;
            idx   <= 2'd0;
          end
        end
        S_ISSUE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          fetch_ptr <= fetch_ptr + 16'd1;
          idx       <= 2'd0;
          state     <= start_cap ? S_ISSUE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (cap_en && (state == S_ISSUE)) word_sr <= push_word;

      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_hit) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop_hit)      level <= level + LEVEL_W'(1);
      else if (!push && pop_hit) level <= level - LEVEL_W'(1);

      if (uf_pop && !discard)      skip_cnt <= skip_cnt + 17'd1;
      else if (!uf_pop && discard) skip_cnt <= skip_cnt - 17'd1;

      if (bus.pop && (word_ptr != 16'hFFFF)) word_ptr <= word_ptr + 16'd1;
      if (uf_pop) underflow <= 1'b1;
    end
  end

  // FIFO storage; contents are qualified by level so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

`ifdef DSA_PACK_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt;
  assign bus.underflow_cnt = uf_cnt;

  // Saturating count of underflow pops, restarted by each pointer load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          uf_cnt <= 16'd0;
    else if (bus.ptr_load)               uf_cnt <= 16'd0;
    else if (uf_pop && uf_cnt != 16'hFFFF) uf_cnt <= uf_cnt + 16'd1;
  end
`else
  assign bus.underflow_cnt = 16'd0;
`endif

endmodule

// File: doc/dsa_out_word_packer.md
Name: dsa_out_word_packer

Overview:
- Downstream of the bilinear core's 8-bit output pixel BRAM; sits between that BRAM's host read port and the host bus.
- Prefetches four consecutive output pixels and packs them into one 32-bit word, little-endian (pixel 4k in bits [7:0]).
- Buffers packed words in a small FIFO so every OUT_DATA read returns a full word in the same cycle and auto-advances.

Parameters:
- IMG_MAX_W, default 32: maximum image width in pixels.
- IMG_MAX_H, default 32: maximum image height in pixels.
- FIFO_DEPTH, default 4: number of packed-word entries; power of two, at least 2.
- Derived, not overridable: PIX_ADDR_W = $clog2(IMG_MAX_W*IMG_MAX_H).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ptr_load  in  1  pulse: host wrote OUT_ADDR.
- ptr_wdata  in  16  new word pointer, in 32-bit words.
- pix_count  in  PIX_ADDR_W+1  valid output pixels (out_w*out_h); sampled on ptr_load.
- pop  in  1  host read of OUT_DATA.
- mem_addr  out  PIX_ADDR_W  byte address to output BRAM port B.
- mem_q  in  8  BRAM read data; valid 1 cycle after mem_addr.
- rdata  out  32  FIFO head word, combinational.
- word_ptr  out  16  word index of the current FIFO head (readback of OUT_ADDR).
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- underflow  out  1  sticky flag: pop arrived before data was ready.
- underflow_cnt  out  16  underflow event counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, FIFO empty, end_words = 0.
- On ptr_load:
  - FIFO is flushed and any in-flight fetch is aborted.
  - fetch_ptr and word_ptr are loaded with ptr_wdata.
  - end_words = ceil(pix_count/4) is latched.
  - underflow is cleared.
  - FSM goes to IDLE.
  - ptr_load wins over a pop and over a fetch completion in the same cycle.
- FSM states:
  - IDLE to ISSUE when fetch_ptr < end_words and level + in_flight < FIFO_DEPTH. The slot is reserved at this point.
  - ISSUE (4 cycles, i = 0..3): mem_addr = fetch_ptr*4 + i, truncated to PIX_ADDR_W. The capture of byte i-1 happens in the same cycle.
  - CAPTURE (1 cycle): capture byte 3, push the word, increment fetch_ptr, return to IDLE.
  - A back-to-back fetch may go directly from CAPTURE to ISSUE.
- Byte masking: a byte whose pixel index is >= pix_count is packed as 0x00.
- Latency: 6 cycles from ptr_load to the first word valid (1 cycle IDLE, 4 cycles ISSUE, 1 cycle CAPTURE). Steady-state throughput is one word per 5 cycles.
- Pop with FIFO non-empty:
  - rdata shows the head in that same cycle.
  - The head is removed at the clock edge.
  - word_ptr increments.
- Pop with FIFO empty and fetch_ptr >= end_words (past end of image):
  - rdata = 0.
  - word_ptr increments, saturating at 0xFFFF.
  - Not an underflow.
- Pop with FIFO empty and fetch_ptr < end_words (data pending):
  - rdata = 0.
  - underflow <= 1.
  - word_ptr increments and the pending word is discarded when it arrives (skip counter).
  - The stream stays aligned.
- Pop and push in the same cycle: both take effect and level is unchanged. Full FIFO never occurs, because a slot is reserved before issue.
- fetch_ptr is 16 bits. Word addresses beyond the memory wrap through PIX_ADDR_W truncation. Bytes masked by pix_count are the only guaranteed values there.
- rst_n asserted mid-fetch: immediate return to the reset state. BRAM contents are untouched.

Optional Feature:
- Macro: DSA_PACK_UNDERFLOW_CNT_EN.
- Defined: underflow_cnt increments on every underflow pop, saturates at 0xFFFF, and is cleared on ptr_load.
- Undefined: underflow_cnt is tied to 0 and no counter logic is synthesized. The sticky underflow flag exists in both builds.

Test Plan:
- BRAM bytes 0..7 = 0x10..0x17, pix_count = 8, ptr_load(0), wait 12 cycles, pop twice -> rdata 0x13121110 then 0x17161514; underflow = 0; word_ptr = 2.
- pix_count = 6, same data, ptr_load(1), wait, pop -> 0x00001514; next pop -> 0x00000000 with underflow still 0.
- ptr_load(0), pop on the cycle immediately after -> rdata 0, underflow = 1, underflow_cnt = 1 (macro on) or 0 (macro off). The next valid pop returns 0x17161514 (word 0 skipped).
- FIFO_DEPTH = 4, pix_count = 64, no pops for 40 cycles -> level = 4 and mem_addr stays idle. One pop -> refill to 4 within 6 cycles.
- ptr_load(2) while an ISSUE is in progress -> FIFO flushed, level = 0. The first word after refill equals bytes 8..11.
- Assert rst_n low mid-ISSUE for 1 cycle -> rdata = 0, level = 0, word_ptr = 0, underflow = 0.
